// File: rtl/mont_mul_cios.sv
// Word-serial Montgomery multiplier (CIOS): result = a*b*R^-1 mod n, R = 2^(W*NWORDS).
// Optional n0prime self-check compiled in with MONT_N0CHECK_EN.
module mont_mul_cios #(
  parameter int W      = 32,
  parameter int NWORDS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W*NWORDS-1:0]   a,
  input  logic [W*NWORDS-1:0]   b,
  input  logic [W*NWORDS-1:0]   n,
  input  logic [W-1:0]          n0prime,
  output logic [W*NWORDS-1:0]   result,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int K  = W * NWORDS;
  // t holds up to 2n + (2^W-1)*n after a multiply step, and t + m*n before the shift,
  // so the register carries W extra bits above the K+2 bit reduced accumulator.
  localparam int TW = K + W + 2;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, MULA, REDC, FINAL} state_t;

  state_t          state_q;
  logic [K-1:0]    a_q, b_q, n_q, result_q;
  logic [W-1:0]    n0_q;
  logic [TW-1:0]   t_q;
  logic [IW-1:0]   i_q;
  logic            busy_q, done_q;

  logic [W-1:0]    a_word;
  logic [W-1:0]    m_word;
  logic [TW-1:0]   mula_t, redc_sum, redc_t, fin_t;

  assign a_word   = a_q[i_q*W +: W];
  assign mula_t   = t_q + (TW'(a_word) * TW'(b_q));
  assign m_word   = t_q[W-1:0] * n0_q;
  assign redc_sum = t_q + (TW'(m_word) * TW'(n_q));
  assign redc_t   = redc_sum >> W;
  assign fin_t    = (t_q >= TW'(n_q)) ? (t_q - TW'(n_q)) : t_q;

`ifdef MONT_N0CHECK_EN
  logic [W-1:0] chk_prod;
  logic         chk_bad;
  logic         err_pend_q, err_q;

  assign chk_prod = n[W-1:0] * n0prime;
  assign chk_bad  = (chk_prod != {W{1'b1}});
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      n0_q     <= '0;
      t_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MONT_N0CHECK_EN
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            n_q     <= n;
            n0_q    <= n0prime;
            t_q     <= '0;
            i_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= MULA;
`ifdef MONT_N0CHECK_EN
            err_pend_q <= chk_bad;
            err_q      <= 1'b0;
`endif
          end
        end
        MULA: begin
          t_q     <= mula_t;
          state_q <= REDC;
`ifdef MONT_N0CHECK_EN
          // A bad n0prime skips the whole loop; t is don't-care since result is forced to 0.
          if (err_pend_q) begin
            state_q <= FINAL;
            busy_q  <= 1'b0;
          end
`endif
        end
        REDC: begin
          t_q <= redc_t;
          if (i_q == IW'(NWORDS - 1)) begin
            state_q <= FINAL;
            busy_q  <= 1'b0;
          end else begin
            i_q     <= i_q + 1'b1;
            state_q <= MULA;
          end
        end
        FINAL: begin
          result_q <= K'(fin_t);
          done_q   <= 1'b1;
          state_q  <= IDLE;
`ifdef MONT_N0CHECK_EN
          if (err_pend_q) result_q <= '0;
          err_q <= err_pend_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
